// File: rtl/toll_class_controller.sv
// Toll lane controller: class FIFO, fee/revenue accounting, gate and alarm sequencing.
// Optional per-class statistics counters are enabled with `define CLASS_STATS_EN.
module toll_class_controller #(
  parameter logic [7:0] FEE_BIKE     = 8'd10,
  parameter logic [7:0] FEE_CAR      = 8'd20,
  parameter logic [7:0] FEE_BUS      = 8'd50,
  parameter logic [7:0] FEE_TRUCK    = 8'd80,
  parameter int         GATE_CYCLES  = 16,
  parameter int         ALARM_CYCLES = 8,
  parameter int         TOTAL_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         uart_data,
  input  logic               uart_valid,
  output logic               gate_open,
  output logic [7:0]         fee,
  output logic               fee_valid,
  output logic [TOTAL_W-1:0] total_revenue,
  output logic [15:0]        vehicle_count,
  output logic               alarm,
  output logic               fifo_full,
  output logic               overflow
`ifdef CLASS_STATS_EN
  ,
  input  logic [2:0]         stat_sel,
  output logic [15:0]        stat_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHARGE,
    S_OPEN,
    S_ALARM
  } state_t;

  localparam logic [2:0]  CLS_INVALID = 3'b111;
  localparam logic [15:0] GATE_LOAD   = 16'(GATE_CYCLES - 1);
  localparam logic [15:0] ALARM_LOAD  = 16'(ALARM_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic [2:0]  cls_q;

  logic [2:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [2:0]  head;
  logic        frame;
  logic        push;
  logic        pop;

  logic [TOTAL_W:0] sum;

  function automatic logic [7:0] fee_of(input logic [2:0] c);
    logic [7:0] f;
    f = 8'd0;
    unique case (c)
      3'b001:  f = FEE_BIKE;
      3'b010:  f = FEE_CAR;
      3'b011:  f = FEE_BUS;
      3'b100:  f = FEE_TRUCK;
      default: f = 8'd0;
    endcase
    return f;
  endfunction

  // Full is judged before this cycle's pop, so a pop never frees room for a same-cycle push.
  assign fifo_full = (count == 3'd4);
  assign frame     = uart_valid && (uart_data != 3'b000);
  assign push      = frame && !fifo_full;
  assign pop       = (state_q == S_IDLE) && (count != 3'd0);
  assign head      = mem[rd_ptr];

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
      if (frame && fifo_full) overflow <= 1'b1;
    end
  end

  // FSM state, timer and the class being serviced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= 16'd0;
      cls_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (pop) cls_q <= head;
    end
  end

  // Next-state logic and lane outputs.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    gate_open = 1'b0;
    alarm     = 1'b0;
    fee_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count != 3'd0) state_d = S_CHARGE;
      end
      S_CHARGE: begin
        if (cls_q == CLS_INVALID) begin
          state_d = S_ALARM;
          timer_d = ALARM_LOAD;
        end else begin
          fee_valid = 1'b1;
          state_d   = S_OPEN;
          timer_d   = GATE_LOAD;
        end
      end
      S_OPEN: begin
        gate_open = 1'b1;
        if (timer_q == 16'd0) state_d = S_IDLE;
        else                  timer_d = timer_q - 16'd1;
      end
      S_ALARM: begin
        alarm = 1'b1;
        if (timer_q == 16'd0) state_d = S_IDLE;
        else                  timer_d = timer_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sum = {1'b0, total_revenue} + (TOTAL_W + 1)'(fee);

  // Fee is latched at pop so it is already valid during the CHARGE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fee           <= 8'd0;
      total_revenue <= '0;
      vehicle_count <= 16'd0;
    end else begin
      if (pop && head != CLS_INVALID) fee <= fee_of(head);
      if (fee_valid) begin
        total_revenue <= sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];
        if (vehicle_count != 16'hFFFF) vehicle_count <= vehicle_count + 16'd1;
      end
    end
  end

`ifdef CLASS_STATS_EN
  logic [15:0] stats [7];
  logic [2:0]  stat_idx;
  logic [2:0]  sel_idx;

  // Slot 0 holds invalid frames; slots 1..6 follow the class code.
  assign stat_idx = (cls_q == CLS_INVALID) ? 3'd0 : cls_q;
  assign sel_idx  = (stat_sel == CLS_INVALID) ? 3'd0 : stat_sel;

  // Per-class saturating counters and registered readout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) stats[i] <= 16'd0;
      stat_count <= 16'd0;
    end else begin
      if (state_q == S_CHARGE && stats[stat_idx] != 16'hFFFF)
        stats[stat_idx] <= stats[stat_idx] + 16'd1;
      stat_count <= stats[sel_idx];
    end
  end
`endif

endmodule

// File: tb/tb_toll_class_controller.sv
// Scoreboard bench for toll_class_controller with a transaction-level lane model.
// A second 8-bit-revenue instance exercises accumulator saturation.
module tb_toll_class_controller;

  localparam int GATE = 16;
  localparam int ALRM = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  d = 3'd0;
  logic        v = 1'b0;
  logic [2:0]  d2 = 3'd0;
  logic        v2 = 1'b0;

  logic        gate, fv, alm, full, ovf;
  logic [7:0]  fee;
  logic [15:0] total, vcnt;
  logic        gate2, fv2, alm2, full2, ovf2;
  logic [7:0]  fee2;
  logic [7:0]  total2;
  logic [15:0] vcnt2;
`ifdef CLASS_STATS_EN
  logic [2:0]  ss = 3'd0;
  logic [15:0] sc, sc2;
`endif

  int vectors = 0;
  int errors = 0;

  toll_class_controller dut (
    .clk(clk), .reset(reset), .uart_data(d), .uart_valid(v),
    .gate_open(gate), .fee(fee), .fee_valid(fv),
    .total_revenue(total), .vehicle_count(vcnt), .alarm(alm),
    .fifo_full(full), .overflow(ovf)
`ifdef CLASS_STATS_EN
    , .stat_sel(ss), .stat_count(sc)
`endif
  );

  toll_class_controller #(.TOTAL_W(8)) dut8 (
    .clk(clk), .reset(reset), .uart_data(d2), .uart_valid(v2),
    .gate_open(gate2), .fee(fee2), .fee_valid(fv2),
    .total_revenue(total2), .vehicle_count(vcnt2), .alarm(alm2),
    .fifo_full(full2), .overflow(ovf2)
`ifdef CLASS_STATS_EN
    , .stat_sel(ss), .stat_count(sc2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int fee_of(input logic [2:0] c);
    case (c)
      3'd1: return 10;
      3'd2: return 20;
      3'd3: return 50;
      3'd4: return 80;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    int fee;
    int total;
    int count;
  } exp_t;

  // Lane model: a queue of waiting vehicles and a server busy for a
  // known service time (1 charge cycle plus the gate or alarm time).
  logic [2:0] mq[$];
  exp_t       sb[$];
  int         busy = 0;
  bit         m_ovf = 0;
  int         m_total = 0;
  int         m_count = 0;

  always @(posedge clk or posedge reset) begin
    bit acc;
    logic [2:0] h;
    if (reset) begin
      mq.delete();
      sb.delete();
      busy = 0;
      m_ovf = 0;
      m_total = 0;
      m_count = 0;
    end else begin
      acc = v && d != 3'd0 && mq.size() < 4;
      if (v && d != 3'd0 && mq.size() == 4) m_ovf = 1;
      if (busy == 0 && mq.size() > 0) begin
        h = mq.pop_front();
        if (h == 3'd7) begin
          busy = 1 + ALRM;
        end else begin
          busy = 1 + GATE;
          m_total = m_total + fee_of(h);
          if (m_total > 65535) m_total = 65535;
          if (m_count < 65535) m_count = m_count + 1;
          sb.push_back('{fee_of(h), m_total, m_count});
        end
      end else if (busy > 0) begin
        busy = busy - 1;
      end
      if (acc) mq.push_back(d);
    end
  end

  // Monitor: pops expectations on fee_valid and checks lane timing.
  bit   pend = 0;
  exp_t pe;
  int   grun = 0;
  int   arun = 0;

  always @(negedge clk) begin
    if (reset) begin
      pend = 0;
      grun = 0;
      arun = 0;
    end else begin
      if (pend) begin
        chk("total_revenue", int'(total), pe.total);
        chk("vehicle_count", int'(vcnt), pe.count);
        pend = 0;
      end
      if (fv) begin
        if (sb.size() == 0) begin
          chk("unexpected_fee_valid", 1, 0);
        end else begin
          pe = sb.pop_front();
          chk("fee", int'(fee), pe.fee);
          pend = 1;
        end
      end
      if (gate) grun++;
      else if (grun > 0) begin
        chk("gate_open_len", grun, GATE);
        grun = 0;
      end
      if (alm) arun++;
      else if (arun > 0) begin
        chk("alarm_len", arun, ALRM);
        arun = 0;
      end
      chk("gate_and_alarm", int'(gate && alm), 0);
      chk("fifo_full", int'(full), int'(mq.size() == 4));
      chk("overflow", int'(ovf), int'(m_ovf));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [2:0] c);
    d = c;
    v = 1'b1;
    @(posedge clk);
    #1;
    v = 1'b0;
    d = 3'd0;
  endtask

  task automatic drain();
    int n = 0;
    while ((mq.size() > 0 || busy > 0 || pend) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", n, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_gate();
    int n = 0;
    while (!gate && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("gate_wait_timeout", n, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_outputs", int'({gate, fee, fv, total, vcnt, alm, full, ovf}), 0);
    do_reset();

    send(3'd2);
    @(negedge clk);
    chk("lat_t1_fee_valid", int'(fv), 0);
    @(negedge clk);
    chk("lat_t2_fee_valid", int'(fv), 1);
    chk("lat_t2_fee", int'(fee), 20);
    chk("lat_t2_gate", int'(gate), 0);
    @(negedge clk);
    chk("lat_t3_gate", int'(gate), 1);
    drain();
    chk("single_total", int'(total), 20);
    chk("single_count", int'(vcnt), 1);

    do_reset();
    send(3'd1);
    send(3'd3);
    send(3'd4);
    send(3'd5);
    chk("four_no_overflow", int'(ovf), 0);
    drain();
    chk("four_total", int'(total), 140);
    chk("four_count", int'(vcnt), 4);

    send(3'd7);
    drain();
    chk("invalid_total", int'(total), 140);
    chk("invalid_count", int'(vcnt), 4);

    do_reset();
    send(3'd2);
    wait_gate();
    #1;
    send(3'd0);
    send(3'd1);
    send(3'd3);
    send(3'd4);
    send(3'd6);
    send(3'd2);
    send(3'd5);
    chk("burst_full", int'(full), 1);
    chk("burst_overflow", int'(ovf), 1);
    drain();
    chk("burst_overflow_sticky", int'(ovf), 1);
    chk("burst_count", int'(vcnt), 5);
    chk("burst_total", int'(total), 20 + 10 + 50 + 80 + 0);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) == 0);
      d = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
    end
    v = 1'b0;
    d = 3'd0;
    drain();
    chk("random_total", int'(total), m_total);
    chk("random_count", int'(vcnt), m_count);

    for (int i = 0; i < 4; i++) begin
      d2 = 3'd4;
      v2 = 1'b1;
      @(posedge clk);
      #1;
    end
    v2 = 1'b0;
    d2 = 3'd0;
    repeat (100) @(posedge clk);
    #1;
    chk("sat_total8", int'(total2), 255);
    chk("sat_count8", int'(vcnt2), 4);

    do_reset();
    send(3'd4);
    send(3'd1);
    wait_gate();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_gate", int'(gate), 0);
    chk("mid_reset_full", int'(full), 0);
    chk("mid_reset_total", int'(total), 0);
    chk("mid_reset_count", int'(vcnt), 0);
    chk("mid_reset_fee", int'({fee, fv, alm, ovf}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("post_reset_count", int'(vcnt), 0);
    chk("post_reset_gate", int'(gate), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
